// File: rtl/level_crossing_pkg.sv
// Shared definitions for the level-crossing blocks: counting-point state
// encoding, sensor-pair codes and defaults shared with the gate controller.
package level_crossing_pkg;

   localparam int CNT_W_DEFAULT = 4;
   localparam int NUM_BOGEYS    = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      A1    = 3'd1,
      AB    = 3'd2,
      A2    = 3'd3,
      B1    = 3'd4,
      BA    = 3'd5,
      B2    = 3'd6,
      FAULT = 3'd7
   } acp_state_e;

   // Filtered sensor pair, bit 1 = sensor A, bit 0 = sensor B.
   localparam logic [1:0] PAIR_NONE = 2'b00;
   localparam logic [1:0] PAIR_A    = 2'b10;
   localparam logic [1:0] PAIR_B    = 2'b01;
   localparam logic [1:0] PAIR_AB   = 2'b11;

   function automatic logic is_tracking(input acp_state_e st);
      return (st != IDLE) && (st != FAULT);
   endfunction

endpackage

// File: rtl/axle_counter_point_sensor_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer for one wheel
// sensor; the filtered level moves only after DEBOUNCE_CYCLES disagreeing samples.
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic raw,
   output logic filt
);

   localparam int RUN_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic             filt_q, filt_d;
   logic [RUN_W-1:0] run_q, run_d;

   always_comb begin
      sync_d = {sync_q[0], raw};
   end

   // A single agreeing sample restarts the run, so short glitches never reach filt.
   always_comb begin
      filt_d = filt_q;
      run_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (run_q == RUN_LAST) begin
            filt_d = sync_q[1];
            run_d  = '0;
         end else begin
            filt_d = filt_q;
            run_d  = run_q + RUN_W'(1);
         end
      end else begin
         run_d = '0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_q <= 2'b00;
         filt_q <= 1'b0;
         run_q  <= '0;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         run_q  <= run_d;
      end
   end

   assign filt = filt_q;

endmodule

// File: rtl/axle_counter_point.sv
// Axle counting point: decodes the occlusion order of two debounced wheel
// sensors into saturating A->B and B->A bogey counts with sticky fault detection.
module axle_counter_point
   import level_crossing_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int CNT_W           = CNT_W_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             sensor_a,
   input  logic             sensor_b,
   input  logic             clear,
   output logic [CNT_W-1:0] Count_a2b,
   output logic [CNT_W-1:0] Count_b2a,
   output logic             inc_a2b,
   output logic             inc_b2a,
   output logic             busy,
   output logic             fault
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic             fa_s, fb_s;
   logic [1:0]       pair_s;
   acp_state_e       state_q, state_d, fsm_next_s;
   logic             done_a2b_s, done_b2a_s, timeout_s;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] cnt_a2b_q, cnt_a2b_d, cnt_b2a_q, cnt_b2a_d;
   logic             inc_a2b_q, inc_a2b_d, inc_b2a_q, inc_b2a_d;
   logic             busy_q, busy_d, fault_q, fault_d;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .raw     (sensor_a),
      .filt    (fa_s)
   );

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .raw     (sensor_b),
      .filt    (fb_s)
   );

   assign pair_s = {fa_s, fb_s};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Each tracking state accepts hold, one step forward or one step back.
   always_comb begin
      fsm_next_s = state_q;
      done_a2b_s = 1'b0;
      done_b2a_s = 1'b0;
      case (state_q)
         IDLE: begin
            case (pair_s)
               PAIR_NONE: fsm_next_s = IDLE;
               PAIR_A:    fsm_next_s = A1;
               PAIR_B:    fsm_next_s = B1;
               default:   fsm_next_s = FAULT;
            endcase
         end
         A1: begin
            case (pair_s)
               PAIR_A:    fsm_next_s = A1;
               PAIR_NONE: fsm_next_s = IDLE;
               PAIR_AB:   fsm_next_s = AB;
               default:   fsm_next_s = FAULT;
            endcase
         end
         AB: begin
            case (pair_s)
               PAIR_AB: fsm_next_s = AB;
               PAIR_A:  fsm_next_s = A1;
               PAIR_B:  fsm_next_s = A2;
               default: fsm_next_s = FAULT;
            endcase
         end
         A2: begin
            case (pair_s)
               PAIR_B:    fsm_next_s = A2;
               PAIR_NONE: begin
                  fsm_next_s = IDLE;
                  done_a2b_s = 1'b1;
               end
               PAIR_AB:   fsm_next_s = AB;
               default:   fsm_next_s = FAULT;
            endcase
         end
         B1: begin
            case (pair_s)
               PAIR_B:    fsm_next_s = B1;
               PAIR_NONE: fsm_next_s = IDLE;
               PAIR_AB:   fsm_next_s = BA;
               default:   fsm_next_s = FAULT;
            endcase
         end
         BA: begin
            case (pair_s)
               PAIR_AB: fsm_next_s = BA;
               PAIR_B:  fsm_next_s = B1;
               PAIR_A:  fsm_next_s = B2;
               default: fsm_next_s = FAULT;
            endcase
         end
         B2: begin
            case (pair_s)
               PAIR_A:    fsm_next_s = B2;
               PAIR_NONE: begin
                  fsm_next_s = IDLE;
                  done_b2a_s = 1'b1;
               end
               PAIR_AB:   fsm_next_s = BA;
               default:   fsm_next_s = FAULT;
            endcase
         end
         FAULT:   fsm_next_s = FAULT;
         default: fsm_next_s = FAULT;
      endcase
   end

   assign timeout_s = is_tracking(state_q) && (fsm_next_s == state_q) && (tmo_q == TMO_LAST);

   // Clear outranks everything, including a pending fault or completion.
   always_comb begin
      if (clear) begin
         state_d = IDLE;
      end else if (timeout_s) begin
         state_d = FAULT;
      end else begin
         state_d = fsm_next_s;
      end
   end

   always_comb begin
      if (clear || (state_d != state_q) || !is_tracking(state_q)) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   // Saturating counters; a blocked increment also suppresses its strobe.
   always_comb begin
      cnt_a2b_d = cnt_a2b_q;
      cnt_b2a_d = cnt_b2a_q;
      inc_a2b_d = 1'b0;
      inc_b2a_d = 1'b0;
      if (clear) begin
         cnt_a2b_d = '0;
         cnt_b2a_d = '0;
      end else begin
         if (done_a2b_s && (cnt_a2b_q != CNT_MAX)) begin
            cnt_a2b_d = cnt_a2b_q + CNT_W'(1);
            inc_a2b_d = 1'b1;
         end else begin
            cnt_a2b_d = cnt_a2b_q;
         end
         if (done_b2a_s && (cnt_b2a_q != CNT_MAX)) begin
            cnt_b2a_d = cnt_b2a_q + CNT_W'(1);
            inc_b2a_d = 1'b1;
         end else begin
            cnt_b2a_d = cnt_b2a_q;
         end
      end
   end

   always_comb begin
      busy_d  = (state_d != IDLE);
      fault_d = (state_d == FAULT);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         tmo_q     <= '0;
         cnt_a2b_q <= '0;
         cnt_b2a_q <= '0;
         inc_a2b_q <= 1'b0;
         inc_b2a_q <= 1'b0;
         busy_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         cnt_a2b_q <= cnt_a2b_d;
         cnt_b2a_q <= cnt_b2a_d;
         inc_a2b_q <= inc_a2b_d;
         inc_b2a_q <= inc_b2a_d;
         busy_q    <= busy_d;
         fault_q   <= fault_d;
      end
   end

   assign Count_a2b = cnt_a2b_q;
   assign Count_b2a = cnt_b2a_q;
   assign inc_a2b   = inc_a2b_q;
   assign inc_b2a   = inc_b2a_q;
   assign busy      = busy_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_axle_counter_point.sv
// Scoreboard bench for axle_counter_point: a path-position reference model
// predicts strobes and counts, and a negedge monitor checks every strobe.
module tb_axle_counter_point;

   localparam int DEB  = 4;
   localparam int TMO  = 64;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sa = 1'b0;
   logic          sb = 1'b0;
   logic          clr = 1'b0;
   logic [CW-1:0] ca, cb;
   logic          ia, ib, busy, fault;

   always #5 clk = ~clk;

   axle_counter_point #(
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TMO),
      .CNT_W           (CW)
   ) dut (
      .Clk       (clk),
      .Reset_n   (rst_n),
      .sensor_a  (sa),
      .sensor_b  (sb),
      .clear     (clr),
      .Count_a2b (ca),
      .Count_b2a (cb),
      .inc_a2b   (ia),
      .inc_b2a   (ib),
      .busy      (busy),
      .fault     (fault)
   );

   typedef struct { int dir; int cnt; } exp_t;
   exp_t sb_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int strobes_a = 0;
   int busy_hits = 0;
   bit watch_busy = 1'b0;

   // Model: a bogey walks a 4-step path of sensor pairs; position 4 = counted.
   int path_a[4] = '{0, 2, 3, 1};
   int path_b[4] = '{0, 1, 3, 2};
   int m_dir = 0, m_pos = 0, m_fault = 0, m_ca = 0, m_cb = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endfunction

   function automatic int pth(input int dir, input int i);
      return (dir == 1) ? path_a[i] : path_b[i];
   endfunction

   function automatic void mdl_clear();
      m_dir = 0; m_pos = 0; m_fault = 0; m_ca = 0; m_cb = 0;
   endfunction

   function automatic void mdl_count(input int dir);
      if (dir == 1 && m_ca < MAXC) begin
         m_ca++;
         sb_q.push_back('{1, m_ca});
      end else if (dir == 2 && m_cb < MAXC) begin
         m_cb++;
         sb_q.push_back('{2, m_cb});
      end
   endfunction

   function automatic void mdl_apply(input int p);
      if (m_fault != 0) return;
      if (m_dir == 0) begin
         if (p == 2) begin m_dir = 1; m_pos = 1; end
         else if (p == 1) begin m_dir = 2; m_pos = 1; end
         else if (p == 3) m_fault = 1;
         return;
      end
      if (p == pth(m_dir, m_pos)) return;
      if (p == pth(m_dir, (m_pos + 1) % 4)) begin
         m_pos++;
         if (m_pos == 4) begin
            mdl_count(m_dir);
            m_dir = 0; m_pos = 0;
         end
      end else if (p == pth(m_dir, m_pos - 1)) begin
         m_pos--;
         if (m_pos == 0) m_dir = 0;
      end else begin
         m_fault = 1;
      end
   endfunction

   task automatic got_strobe(input int dir, input int val);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL strobe_unexpected: dir %0d count %0d, required no strobe", dir, val);
      end else begin
         e = sb_q.pop_front();
         check("strobe_dir", dir, e.dir);
         check("strobe_count", val, e.cnt);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (ia) begin
            strobes_a++;
            got_strobe(1, int'(ca));
         end
         if (ib) got_strobe(2, int'(cb));
         if (watch_busy && busy) busy_hits++;
      end
   end

   task automatic step(input int p, input int hold);
      @(posedge clk);
      #1;
      sa = p[1];
      sb = p[0];
      mdl_apply(p);
      repeat (hold) @(posedge clk);
   endtask

   task automatic seq(input int dir, input int hold);
      for (int i = 1; i <= 4; i++) step(pth(dir, i % 4), hold);
   endtask

   task automatic check_state(input string tag);
      @(negedge clk);
      check({tag, ".count_a2b"}, int'(ca), m_ca);
      check({tag, ".count_b2a"}, int'(cb), m_cb);
      check({tag, ".fault"}, int'(fault), m_fault);
      check({tag, ".busy"}, int'(busy), (m_fault != 0 || m_dir != 0) ? 1 : 0);
   endtask

   task automatic do_clear();
      @(posedge clk);
      #1 clr = 1'b1;
      mdl_clear();
      @(posedge clk);
      #1 clr = 1'b0;
   endtask

   initial begin
      int lat, s0, r, p, w;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.count_a2b", int'(ca), 0);
      check("reset.count_b2a", int'(cb), 0);
      check("reset.strobes", int'(ia) + int'(ib), 0);
      check("reset.busy_fault", int'(busy) + int'(fault), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 4; i++) seq(1, 10);
      check_state("a2b_x4");
      check("a2b_x4.strobes", strobes_a, 4);

      // B->A with the strobe latency measured from the final raw release.
      step(1, 10); step(3, 10); step(2, 10);
      @(posedge clk);
      #1 sa = 1'b0; sb = 1'b0;
      mdl_apply(0);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (ib) begin lat = i; break; end
      end
      check("b2a.strobe_latency", lat, DEB + 3);
      repeat (4) @(posedge clk);
      check_state("b2a_latency");

      watch_busy = 1'b1;
      for (int g = 0; g < 3; g++) begin
         w = $urandom_range(1, DEB - 1);
         @(posedge clk);
         #1 sa = 1'b1;
         repeat (w) @(posedge clk);
         #1 sa = 1'b0;
         repeat (10) @(posedge clk);
      end
      watch_busy = 1'b0;
      check("glitch.busy_cycles", busy_hits, 0);
      check_state("glitch");

      step(2, 10); step(3, 10); step(2, 10); step(0, 10);
      check_state("reverse_a");
      step(1, 10); step(3, 10); step(1, 10); step(0, 10);
      check_state("reverse_b");
      step(2, 10); step(3, 10); step(1, 10); step(3, 10); step(1, 10); step(0, 10);
      check_state("rock_then_pass");

      step(3, 10);
      check_state("illegal_11");
      seq(2, 10);
      check_state("frozen_in_fault");
      do_clear();
      check_state("after_clear");
      seq(2, 10);
      check_state("b2a_after_clear");

      step(2, TMO + 10);
      m_fault = 1;
      check_state("timeout");
      step(0, 10);
      do_clear();
      check_state("timeout_cleared");

      s0 = strobes_a;
      for (int i = 0; i < 17; i++) seq(1, $urandom_range(8, 14));
      check_state("saturate");
      check("saturate.strobes", strobes_a - s0, MAXC);

      do_clear();
      seq(1, 10);
      step(2, 10); step(3, 10); step(1, 10);
      @(posedge clk);
      #1 sa = 1'b0; sb = 1'b0;
      repeat (DEB + 2) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      mdl_clear();
      repeat (4) @(posedge clk);
      check_state("clear_collision");

      for (int i = 0; i < 60; i++) begin
         if (m_fault != 0) begin
            step(0, 10);
            do_clear();
         end else begin
            r = $urandom_range(0, 99);
            if (r < 10) p = $urandom_range(0, 3);
            else if (m_dir == 0) p = (r < 55) ? 2 : 1;
            else if (r < 65) p = pth(m_dir, (m_pos + 1) % 4);
            else p = pth(m_dir, m_pos - 1);
            step(p, $urandom_range(8, 14));
         end
         check_state("random");
      end
      step(0, 10);
      do_clear();

      seq(2, 10);
      step(2, 10); step(3, 10);
      check_state("pre_reset");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset.count_a2b", int'(ca), 0);
      check("async_reset.count_b2a", int'(cb), 0);
      check("async_reset.strobes", int'(ia) + int'(ib), 0);
      check("async_reset.busy_fault", int'(busy) + int'(fault), 0);
      sa = 1'b0; sb = 1'b0;
      mdl_clear();
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seq(1, 10);
      check_state("after_reset");

      repeat (4) @(posedge clk);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
